// File: rtl/ntt_agu_multistage.sv
// Address generation unit for a complete N-point NTT (Cooley-Tukey) or
// INTT (Gentleman-Sande) butterfly schedule across all LOG_N stages.
// Each RUN cycle issues one butterfly read pair plus twiddle index. The same
// pair reappears as a write-back PIPE_DEPTH cycles later. A PIPE_DEPTH-cycle
// DRAIN between stages keeps a stage's last write ahead of the next stage's
// first read.
//
// Handshake: there is no back-pressure on the outputs. rd_valid_o and wr_en_o
// are qualifiers only. Whenever either one is low, its address/twiddle outputs
// are held at zero. stall_i suppresses read issue in RUN, and the butterfly
// counter holds for that cycle.
module ntt_agu_multistage #(
    parameter int LOG_N      = 8,
    parameter int PIPE_DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     start_i,
    input  logic                     mode_i,
    input  logic                     stall_i,
    output logic                     busy_o,
    output logic                     done_o,
    output logic [$clog2(LOG_N)-1:0] stage_o,
    output logic                     rd_valid_o,
    output logic [LOG_N-1:0]         rd_addr_a_o,
    output logic [LOG_N-1:0]         rd_addr_b_o,
    output logic [LOG_N-1:0]         twiddle_addr_o,
    output logic                     twiddle_neg_o,
    output logic                     wr_en_o,
    output logic [LOG_N-1:0]         wr_addr_a_o,
    output logic [LOG_N-1:0]         wr_addr_b_o
);

    localparam int SW  = $clog2(LOG_N);
    localparam int BW  = LOG_N - 1;
    localparam int DCW = $clog2(PIPE_DEPTH + 1);
    localparam int LW  = 2 * LOG_N + 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]     state_q;
    logic           mode_q;
    logic [SW-1:0]  stage_q;
    logic [BW-1:0]  bcnt_q;
    logic [DCW-1:0] dcnt_q;
    logic           done_q;

    logic [SW:0]      sh;
    logic [LOG_N-1:0] bx;
    logic [LOG_N-1:0] half_span;
    logic [LOG_N-1:0] grp;
    logic [LOG_N-1:0] ofs;
    logic [LOG_N-1:0] addr_a;
    logic [LOG_N-1:0] addr_b;
    logic [LOG_N-1:0] tw;

    logic [LW-1:0] line_q [PIPE_DEPTH];

    // Schedule FSM: stage and butterfly counters, inter-stage drain, done pulse
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            mode_q  <= 1'b0;
            stage_q <= '0;
            bcnt_q  <= '0;
            dcnt_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            done_q <= (state_q == S_DONE);
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        mode_q  <= mode_i;
                        stage_q <= '0;
                        bcnt_q  <= '0;
                        dcnt_q  <= '0;
                        state_q <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (!stall_i) begin
                        if (&bcnt_q) begin
                            bcnt_q  <= '0;
                            dcnt_q  <= '0;
                            state_q <= S_DRAIN;
                        end else begin
                            bcnt_q <= bcnt_q + 1'b1;
                        end
                    end
                end
                S_DRAIN: begin
                    if (dcnt_q == DCW'(PIPE_DEPTH - 1)) begin
                        dcnt_q <= '0;
                        if (stage_q == SW'(LOG_N - 1)) begin
                            state_q <= S_DONE;
                        end else begin
                            stage_q <= stage_q + 1'b1;
                            state_q <= S_RUN;
                        end
                    end else begin
                        dcnt_q <= dcnt_q + 1'b1;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // Butterfly address math. Both orderings share one form: with
    // H = 1 << sh, g = b >> sh, the pair is (g << (sh+1)) | o and that + H.
    // CT uses sh = LOG_N-1-s and GS uses sh = s.
    always_comb begin
        sh        = mode_q ? {1'b0, stage_q} : ((SW+1)'(LOG_N - 1) - {1'b0, stage_q});
        bx        = {1'b0, bcnt_q};
        half_span = LOG_N'(1) << sh;
        grp       = bx >> sh;
        ofs       = bx & (half_span - 1'b1);
        addr_a    = (grp << (sh + 1'b1)) | ofs;
        addr_b    = addr_a + half_span;
        // (N >> s) - 1 equals the all-ones mask shifted right by s
        tw        = mode_q ? (({LOG_N{1'b1}} >> stage_q) - grp)
                           : ((LOG_N'(1) << stage_q) + grp);
    end

    assign rd_valid_o     = (state_q == S_RUN) && !stall_i;
    assign rd_addr_a_o    = rd_valid_o ? addr_a : '0;
    assign rd_addr_b_o    = rd_valid_o ? addr_b : '0;
    assign twiddle_addr_o = rd_valid_o ? tw : '0;
    assign twiddle_neg_o  = rd_valid_o & mode_q;
    assign busy_o         = (state_q == S_RUN) || (state_q == S_DRAIN);
    assign done_o         = done_q;
    assign stage_o        = stage_q;

    // Write-back delay line: shifts every cycle, including stall and drain
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < PIPE_DEPTH; i++) begin
                line_q[i] <= '0;
            end
        end else begin
            line_q[0] <= {rd_valid_o, rd_addr_a_o, rd_addr_b_o};
            for (int i = 1; i < PIPE_DEPTH; i++) begin
                line_q[i] <= line_q[i-1];
            end
        end
    end

    assign wr_en_o     = line_q[PIPE_DEPTH-1][LW-1];
    assign wr_addr_a_o = wr_en_o ? line_q[PIPE_DEPTH-1][2*LOG_N-1:LOG_N] : '0;
    assign wr_addr_b_o = wr_en_o ? line_q[PIPE_DEPTH-1][LOG_N-1:0] : '0;

endmodule

// File: tb/tb_ntt_agu_multistage.sv
// Scoreboard bench for ntt_agu_multistage (LOG_N=8, PIPE_DEPTH=4).
// Runs an NTT, an INTT, an NTT with a stall and an ignored start, a reset abort,
// and a clean restart after that abort.
module tb_ntt_agu_multistage;

    localparam int LN   = 8;
    localparam int PD   = 4;
    localparam int N    = 1 << LN;
    localparam int HALF = N / 2;
    localparam int SPAN = HALF + PD;
    localparam int RW   = 16 + 3 * LN + 1;
    localparam int WW   = 16 + 2 * LN;
    localparam int NEVER = 1 << 30;

    logic          clk_i = 1'b0;
    logic          rst_ni = 1'b0;
    logic          start_i = 1'b0;
    logic          mode_i = 1'b0;
    logic          stall_i = 1'b0;
    logic          busy_o;
    logic          done_o;
    logic [2:0]    stage_o;
    logic          rd_valid_o;
    logic [LN-1:0] rd_addr_a_o;
    logic [LN-1:0] rd_addr_b_o;
    logic [LN-1:0] twiddle_addr_o;
    logic          twiddle_neg_o;
    logic          wr_en_o;
    logic [LN-1:0] wr_addr_a_o;
    logic [LN-1:0] wr_addr_b_o;

    ntt_agu_multistage #(.LOG_N(LN), .PIPE_DEPTH(PD)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .mode_i(mode_i),
        .stall_i(stall_i), .busy_o(busy_o), .done_o(done_o), .stage_o(stage_o),
        .rd_valid_o(rd_valid_o), .rd_addr_a_o(rd_addr_a_o), .rd_addr_b_o(rd_addr_b_o),
        .twiddle_addr_o(twiddle_addr_o), .twiddle_neg_o(twiddle_neg_o),
        .wr_en_o(wr_en_o), .wr_addr_a_o(wr_addr_a_o), .wr_addr_b_o(wr_addr_b_o)
    );

    // ---------------- clock / reset ----------------
    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    // ---------------- scoreboard state ----------------
    logic [RW-1:0] rd_q[$];
    logic [WW-1:0] wr_q[$];
    int            done_q[$];
    logic [RW-1:0] spot_q[$];
    logic [WW-1:0] wspot_q[$];

    int checks = 0;
    int errors = 0;
    int start_cyc = 0;
    int rd_cnt = 0;
    int wr_cnt = 0;
    bit done_seen = 1'b0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, got, exp, cyc - start_cyc);
        end
    endtask

    // Reference for one butterfly straight from the textbook formulas
    function automatic logic [3*LN:0] model(input bit m, input int s, input int b);
        int h, g, o, a, t;
        logic [LN-1:0] av, bv, tv;
        h  = m ? (1 << s) : (N >> (s + 1));
        g  = b / h;
        o  = b % h;
        a  = 2 * g * h + o;
        t  = m ? ((N >> s) - 1 - g) : ((1 << s) + g);
        av = LN'(a);
        bv = LN'(a + h);
        tv = LN'(t);
        return {av, bv, tv, m};
    endfunction

    task automatic gen_run(input bit m, input int stall_k, input int stall_len);
        logic [3*LN:0] e;
        logic [2*LN-1:0] pair;
        int c;
        for (int s = 0; s < LN; s++) begin
            for (int b = 0; b < HALF; b++) begin
                c = s * SPAN + b + (((s * HALF + b) >= stall_k) ? stall_len : 0);
                e = model(m, s, b);
                pair = e[3*LN:LN+1];
                rd_q.push_back({16'(c), e});
                wr_q.push_back({16'(c + PD), pair});
            end
        end
        done_q.push_back(LN * SPAN + 1 + stall_len);
    endtask

    task automatic spot(input int c, input int a, input int b, input int t, input bit neg);
        spot_q.push_back({16'(c), LN'(a), LN'(b), LN'(t), neg});
    endtask

    task automatic flush_queues();
        rd_q.delete();
        wr_q.delete();
        done_q.delete();
        spot_q.delete();
        wspot_q.delete();
    endtask

    function automatic logic [63:0] all_outputs();
        return 64'({busy_o, done_o, stage_o, rd_valid_o, rd_addr_a_o, rd_addr_b_o,
                    twiddle_addr_o, twiddle_neg_o, wr_en_o, wr_addr_a_o, wr_addr_b_o});
    endfunction

    // ---------------- monitor ----------------
    int            rel;
    logic [15:0]   rel16;
    logic [RW-1:0] rd_e;
    logic [WW-1:0] wr_e;

    always @(negedge clk_i) begin
        rel   = cyc - start_cyc;
        rel16 = 16'(rel);
        if (rd_valid_o) begin
            rd_cnt++;
            if (rd_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rd_unexpected: got read %0d/%0d at cycle %0d, required none",
                         rd_addr_a_o, rd_addr_b_o, rel);
            end else begin
                rd_e = rd_q.pop_front();
                check("rd_seq", 64'({rel16, rd_addr_a_o, rd_addr_b_o, twiddle_addr_o, twiddle_neg_o}), 64'(rd_e));
            end
        end else begin
            check("rd_idle_zero", 64'({rd_addr_a_o, rd_addr_b_o, twiddle_addr_o, twiddle_neg_o}), 64'(0));
        end
        if (spot_q.size() != 0 && spot_q[0][RW-1 -: 16] == rel16) begin
            rd_e = spot_q.pop_front();
            check("rd_spot", 64'({rel16, rd_addr_a_o, rd_addr_b_o, twiddle_addr_o, twiddle_neg_o}), 64'(rd_e));
        end
        if (wr_en_o) begin
            wr_cnt++;
            if (wr_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL wr_unexpected: got write %0d/%0d at cycle %0d, required none",
                         wr_addr_a_o, wr_addr_b_o, rel);
            end else begin
                wr_e = wr_q.pop_front();
                check("wr_seq", 64'({rel16, wr_addr_a_o, wr_addr_b_o}), 64'(wr_e));
            end
        end else begin
            check("wr_idle_zero", 64'({wr_addr_a_o, wr_addr_b_o}), 64'(0));
        end
        if (wspot_q.size() != 0 && wspot_q[0][WW-1 -: 16] == rel16) begin
            wr_e = wspot_q.pop_front();
            check("wr_spot", 64'({rel16, wr_en_o ? wr_addr_a_o : 8'hxx, wr_addr_b_o}), 64'(wr_e));
        end
        if (done_o) begin
            done_seen = 1'b1;
            if (done_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL done_unexpected: got done_o at cycle %0d, required none", rel);
            end else begin
                check("done_cycle", 64'(rel), 64'(done_q.pop_front()));
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic run_begin(input bit m, input int stall_k, input int stall_len);
        @(posedge clk_i);
        #1;
        start_cyc = cyc + 1;
        rd_cnt    = 0;
        wr_cnt    = 0;
        done_seen = 1'b0;
        gen_run(m, stall_k, stall_len);
        start_i = 1'b1;
        mode_i  = m;
        @(posedge clk_i);
        #1;
        start_i = 1'b0;
        mode_i  = ~m;
    endtask

    task automatic wait_rel(input int target);
        int i;
        i = 0;
        while ((cyc - start_cyc) != target && i < 2000) begin
            @(posedge clk_i);
            #1;
            i++;
        end
        check("reach_cycle", 64'(cyc - start_cyc), 64'(target));
    endtask

    task automatic wait_done();
        int i;
        i = 0;
        while (!done_seen && i < 3000) begin
            @(posedge clk_i);
            i++;
        end
        check("done_timeout", 64'(done_seen), 64'(1));
        repeat (2) @(posedge clk_i);
        #1;
        check("rd_count", 64'(rd_cnt), 64'(LN * HALF));
        check("wr_count", 64'(wr_cnt), 64'(LN * HALF));
        check("rd_q_drained", 64'(rd_q.size()), 64'(0));
        check("wr_q_drained", 64'(wr_q.size()), 64'(0));
        check("spot_q_drained", 64'(spot_q.size() + wspot_q.size()), 64'(0));
        check("done_q_drained", 64'(done_q.size()), 64'(0));
        check("busy_after_done", 64'(busy_o), 64'(0));
        flush_queues();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        repeat (3) @(posedge clk_i);
        #1;
        check("reset_outputs", all_outputs(), 64'(0));
        rst_ni = 1'b1;
        repeat (2) @(posedge clk_i);

        // NTT, no stalls
        spot(0, 0, 128, 1, 0);
        spot(127, 127, 255, 1, 0);
        spot(132, 0, 64, 2, 0);
        spot(196, 128, 192, 3, 0);
        spot(924, 0, 1, 128, 0);
        spot(1051, 254, 255, 255, 0);
        wspot_q.push_back({16'd4, 8'd0, 8'd128});
        run_begin(1'b0, NEVER, 0);
        check("busy_in_run", 64'(busy_o), 64'(1));
        wait_done();

        // INTT, no stalls
        spot(0, 0, 1, 255, 1);
        spot(127, 254, 255, 128, 1);
        spot(924, 0, 128, 1, 1);
        run_begin(1'b1, NEVER, 0);
        wait_done();

        // NTT with a 3-cycle stall at stage 2, b=10, and a start pulse while busy
        spot(277, 10, 42, 4, 0);
        run_begin(1'b0, 2 * HALF + 10, 3);
        wait_rel(2 * SPAN + 10);
        check("stage_at_stall", 64'(stage_o), 64'(2));
        stall_i = 1'b1;
        repeat (3) begin
            @(posedge clk_i);
            #1;
        end
        stall_i = 1'b0;
        wait_rel(600);
        start_i = 1'b1;
        mode_i  = 1'b1;
        @(posedge clk_i);
        #1;
        start_i = 1'b0;
        mode_i  = 1'b0;
        wait_done();

        // Reset abort at stage 3, b=50
        run_begin(1'b0, NEVER, 0);
        wait_rel(3 * SPAN + 50);
        check("stage_before_abort", 64'(stage_o), 64'(3));
        rst_ni = 1'b0;
        #1;
        check("abort_outputs_zero", all_outputs(), 64'(0));
        flush_queues();
        repeat (3) @(posedge clk_i);
        #1;
        check("abort_no_done", 64'(done_seen), 64'(0));
        rst_ni = 1'b1;
        repeat (2) @(posedge clk_i);
        #1;
        check("idle_after_abort", all_outputs(), 64'(0));

        // Fresh run after the abort starts from stage 0, b=0
        spot(0, 0, 128, 1, 0);
        spot(132, 0, 64, 2, 0);
        run_begin(1'b0, NEVER, 0);
        wait_done();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

endmodule
